// File: rtl/load_store_unit.sv
// Sub-word load/store adapter for a word-only data memory; byte/halfword stores use read-modify-write.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

`ifdef LSU_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {StIdle, StLoad, StRead, StWrite, StErr} state_e;
`else
   typedef enum logic [2:0] {StIdle, StLoad, StRead, StWrite} state_e;
`endif

   state_e      state_q;
   logic [31:0] addr_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] wd_q;
   logic [31:0] mg_q;

   logic        is_half;
   logic        is_word;
   logic [31:0] addr_lat;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ld_data;
   logic [31:0] mg_d;

   // funct3[1] set covers the word codes 010/011/110/111
   always_comb begin
      is_half  = (funct3[1:0] == 2'b01);
      is_word  = funct3[1];
      addr_lat = addr;
`ifndef LSU_MISALIGN_TRAP_EN
      if (is_half) addr_lat[0] = 1'b0;
      if (is_word) addr_lat[1:0] = 2'b00;
`endif
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign;
   always_comb begin
      misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
   end
`endif

   always_comb begin
      lane_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
      lane_h = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
      unique case (f3_q[1:0])
         2'b00:   ld_data = {{24{~f3_q[2] & lane_b[7]}}, lane_b};
         2'b01:   ld_data = {{16{~f3_q[2] & lane_h[15]}}, lane_h};
         default: ld_data = mem_rd;
      endcase
   end

   always_comb begin
      mg_d = mem_rd;
      if (f3_q[1:0] == 2'b00) begin
         mg_d[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
      end else begin
         mg_d[{addr_q[1], 4'b0000} +: 16] = wd_q[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         done    <= 1'b0;
         rdata   <= 32'h0;
         addr_q  <= 32'h0;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         wd_q    <= 32'h0;
         mg_q    <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
         err     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         err  <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  addr_q <= addr_lat;
                  we_q   <= we;
                  f3_q   <= funct3;
                  wd_q   <= wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                  if (misalign) begin
                     state_q <= StErr;
                  end else
`endif
                  if (!we) begin
                     state_q <= StLoad;
                  end else if (is_word) begin
                     state_q <= StWrite;
                  end else begin
                     state_q <= StRead;
                  end
               end
            end
            StLoad: begin
               rdata   <= ld_data;
               done    <= 1'b1;
               state_q <= StIdle;
            end
            StRead: begin
               mg_q    <= mg_d;
               state_q <= StWrite;
            end
            StWrite: begin
               done    <= 1'b1;
               state_q <= StIdle;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            StErr: begin
               done    <= 1'b1;
               err     <= 1'b1;
               state_q <= StIdle;
            end
`endif
            default: state_q <= StIdle;
         endcase
      end
   end

`ifndef LSU_MISALIGN_TRAP_EN
   assign err = 1'b0;
`endif

   // Gating by rst_n drops a write whose cycle coincides with reset
   assign ready  = (state_q == StIdle);
   assign mem_a  = {addr_q[31:2], 2'b00};
   assign mem_wd = f3_q[1] ? wd_q : mg_q;
   assign mem_we = rst_n & we_q & (state_q == StWrite);

endmodule
